// File: rtl/simd_mem_ctrl.sv
// Instruction/data memory and run controller for the SIMD core.
// Optional sticky out-of-range flag (mem_err) is built when SIMD_MEM_ERR_EN is defined.
module simd_mem_ctrl #(
  parameter int DATA_W     = 16,
  parameter int INST_W     = 18,
  parameter int ADDR_W     = 10,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter int TIMEOUT    = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic              host_re,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [INST_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              start,
  output logic              busy,
  output logic              finished,
  output logic              timeout,
  output logic [15:0]       cycle_count,
  output logic              mem_err,
  output logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] cpu_inst_addr,
  output logic [INST_W-1:0] cpu_inst,
  input  logic [ADDR_W-1:0] cpu_data_addr,
  input  logic              cpu_data_R,
  input  logic              cpu_data_W,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  input  logic              cpu_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] IMEM_LIM    = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DMEM_LIM    = (ADDR_W+1)'(DMEM_DEPTH);
  localparam logic [16:0]     TIMEOUT_LIM = 17'(TIMEOUT);

  logic [INST_W-1:0] imem_r [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];
  logic [1:0]        state_r;

  logic              run_s, start_s;
  logic              imem_ok_s, cdata_ok_s, host_iok_s, host_dok_s;
  logic              cpu_we_s, cpu_re_s, host_dwe_s, host_iwe_s, host_rd_s;
  logic              dmem_we_s;
  logic [DA_W-1:0]   dmem_waddr_s;
  logic [DATA_W-1:0] dmem_wdata_s;
  logic [16:0]       cnt_inc_s;

  assign run_s      = (state_r == ST_RUN);
  assign start_s    = !run_s && start;
  assign imem_ok_s  = {1'b0, cpu_inst_addr} < IMEM_LIM;
  assign cdata_ok_s = {1'b0, cpu_data_addr} < DMEM_LIM;
  assign host_iok_s = {1'b0, host_addr} < IMEM_LIM;
  assign host_dok_s = {1'b0, host_addr} < DMEM_LIM;
  assign cnt_inc_s  = {1'b0, cycle_count} + 17'd1;

  // Core owns the data memory in RUN, host owns both memories otherwise; nothing writes in reset.
  assign cpu_we_s    = rst && run_s && cpu_data_R && cpu_data_W && cdata_ok_s;
  assign cpu_re_s    = run_s && cpu_data_R && !cpu_data_W;
  assign host_dwe_s  = rst && !run_s && host_we && !host_sel && host_dok_s;
  assign host_iwe_s  = rst && !run_s && host_we && host_sel && host_iok_s;
  assign host_rd_s   = !run_s && host_re;

  assign dmem_we_s    = cpu_we_s | host_dwe_s;
  assign dmem_waddr_s = cpu_we_s ? cpu_data_addr[DA_W-1:0] : host_addr[DA_W-1:0];
  assign dmem_wdata_s = cpu_we_s ? cpu_data_out : host_wdata[DATA_W-1:0];

  // Run sequencing: IDLE/HALT wait for start, RUN counts until done or timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= 16'd0;
      cpu_rst_n   <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (cnt_inc_s <= TIMEOUT_LIM) begin
            cycle_count <= cnt_inc_s[15:0];
          end
          // done wins over a timeout landing on the same edge
          if (cpu_done) begin
            state_r   <= ST_HALT;
            finished  <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b0;
          end else if (cnt_inc_s >= TIMEOUT_LIM) begin
            state_r   <= ST_HALT;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b0;
          end
        end
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_r     <= ST_RUN;
            finished    <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= 16'd0;
            busy        <= 1'b1;
            cpu_rst_n   <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

  // Memory arrays carry no reset so contents survive reset and successive runs
  always_ff @(posedge clk) begin
    if (dmem_we_s) begin
      dmem_r[dmem_waddr_s] <= dmem_wdata_s;
    end
    if (host_iwe_s) begin
      imem_r[host_addr[IA_W-1:0]] <= host_wdata;
    end
  end

  // Registered read ports; out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_inst    <= {INST_W{1'b0}};
      cpu_data_in <= {DATA_W{1'b0}};
      host_rdata  <= {DATA_W{1'b0}};
      host_rvalid <= 1'b0;
    end else begin
      cpu_inst    <= imem_ok_s ? imem_r[cpu_inst_addr[IA_W-1:0]] : {INST_W{1'b0}};
      host_rvalid <= host_rd_s;
      if (cpu_re_s) begin
        cpu_data_in <= cdata_ok_s ? dmem_r[cpu_data_addr[DA_W-1:0]] : {DATA_W{1'b0}};
      end
      if (host_rd_s) begin
        host_rdata <= host_dok_s ? dmem_r[host_addr[DA_W-1:0]] : {DATA_W{1'b0}};
      end
    end
  end

`ifdef SIMD_MEM_ERR_EN
  logic mem_err_r;

  // Sticky flag for any out-of-range core fetch or data access, cleared by start
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_err_r <= 1'b0;
    end else if (start_s) begin
      mem_err_r <= 1'b0;
    end else if (run_s && (!imem_ok_s || (cpu_data_R && !cdata_ok_s))) begin
      mem_err_r <= 1'b1;
    end else begin
      mem_err_r <= mem_err_r;
    end
  end

  assign mem_err = mem_err_r;
`else
  logic unused_s;
  assign unused_s = start_s;
  assign mem_err  = 1'b0;
`endif

endmodule

// File: tb/tb_simd_mem_ctrl.sv
// Self-checking bench for simd_mem_ctrl: spec-level model compared every cycle plus directed literals.
module tb_simd_mem_ctrl;

  localparam int TO = 20;
  localparam int DD = 512;
  localparam int ID = 1024;

`ifdef SIMD_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        host_we, host_re, host_sel;
  logic [9:0]  host_addr;
  logic [17:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        start, busy, finished, timeout;
  logic [15:0] cycle_count;
  logic        mem_err, cpu_rst_n;
  logic [9:0]  cpu_inst_addr;
  logic [17:0] cpu_inst;
  logic [9:0]  cpu_data_addr;
  logic        cpu_data_R, cpu_data_W;
  logic [15:0] cpu_data_out, cpu_data_in;
  logic        cpu_done;

  always #5 clk = ~clk;

  simd_mem_ctrl #(
    .DATA_W(16), .INST_W(18), .ADDR_W(10),
    .IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_re(host_re), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .start(start), .busy(busy), .finished(finished), .timeout(timeout),
    .cycle_count(cycle_count), .mem_err(mem_err), .cpu_rst_n(cpu_rst_n),
    .cpu_inst_addr(cpu_inst_addr), .cpu_inst(cpu_inst),
    .cpu_data_addr(cpu_data_addr), .cpu_data_R(cpu_data_R), .cpu_data_W(cpu_data_W),
    .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in), .cpu_done(cpu_done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: memories as plain arrays with written-flags, run as a flag plus integer count.
  logic [15:0] m_dmem [DD];
  bit          m_dv   [DD];
  logic [17:0] m_imem [ID];
  bit          m_iv   [ID];
  bit          m_run, m_fin, m_to, m_err, m_rv;
  int          m_cnt;
  logic [15:0] m_rdata, m_din;
  logic [17:0] m_inst;
  bit          m_rdata_k, m_din_k, m_inst_k;

  always @(posedge clk) begin
    if (!rst) begin
      m_run <= 1'b0; m_fin <= 1'b0; m_to <= 1'b0; m_err <= 1'b0; m_rv <= 1'b0;
      m_cnt <= 0;
      m_rdata <= 16'h0; m_din <= 16'h0; m_inst <= 18'h0;
      m_rdata_k <= 1'b1; m_din_k <= 1'b1; m_inst_k <= 1'b1;
    end else begin
      m_inst   <= m_imem[cpu_inst_addr];
      m_inst_k <= m_iv[cpu_inst_addr];
      if (m_run) begin
        m_rv  <= 1'b0;
        m_cnt <= (m_cnt + 1 > TO) ? m_cnt : m_cnt + 1;
        if (cpu_done || m_cnt + 1 >= TO) begin
          m_run <= 1'b0;
          m_fin <= cpu_done;
          m_to  <= !cpu_done;
        end
        if (cpu_data_R && cpu_data_W && cpu_data_addr < DD) begin
          m_dmem[cpu_data_addr[8:0]] <= cpu_data_out;
          m_dv[cpu_data_addr[8:0]]   <= 1'b1;
        end
        if (cpu_data_R && !cpu_data_W) begin
          m_din   <= (cpu_data_addr < DD) ? m_dmem[cpu_data_addr[8:0]] : 16'h0;
          m_din_k <= (cpu_data_addr < DD) ? m_dv[cpu_data_addr[8:0]] : 1'b1;
        end
        if (ERR_EN && cpu_data_R && cpu_data_addr >= DD) m_err <= 1'b1;
      end else begin
        m_rv <= host_re;
        if (host_re) begin
          m_rdata   <= (host_addr < DD) ? m_dmem[host_addr[8:0]] : 16'h0;
          m_rdata_k <= (host_addr < DD) ? m_dv[host_addr[8:0]] : 1'b1;
        end
        if (host_we && host_sel) begin
          m_imem[host_addr] <= host_wdata;
          m_iv[host_addr]   <= 1'b1;
        end
        if (host_we && !host_sel && host_addr < DD) begin
          m_dmem[host_addr[8:0]] <= host_wdata[15:0];
          m_dv[host_addr[8:0]]   <= 1'b1;
        end
        if (start) begin
          m_run <= 1'b1; m_fin <= 1'b0; m_to <= 1'b0; m_cnt <= 0; m_err <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", {31'd0, busy}, {31'd0, m_run});
      chk("m_cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, m_run});
      chk("m_finished", {31'd0, finished}, {31'd0, m_fin});
      chk("m_timeout", {31'd0, timeout}, {31'd0, m_to});
      chk("m_cycle_count", {16'd0, cycle_count}, m_cnt);
      chk("m_mem_err", {31'd0, mem_err}, {31'd0, m_err});
      chk("m_host_rvalid", {31'd0, host_rvalid}, {31'd0, m_rv});
      if (m_rdata_k) chk("m_host_rdata", {16'd0, host_rdata}, {16'd0, m_rdata});
      if (m_din_k)   chk("m_cpu_data_in", {16'd0, cpu_data_in}, {16'd0, m_din});
      if (m_inst_k)  chk("m_cpu_inst", {14'd0, cpu_inst}, {14'd0, m_inst});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic sel, input logic [9:0] a, input logic [17:0] d);
    host_we = 1'b1; host_sel = sel; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic hread(input logic [9:0] a);
    host_re = 1'b1; host_addr = a;
    tick();
    host_re = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; host_we = 1'b0; host_re = 1'b0; host_sel = 1'b0;
    host_addr = 10'd0; host_wdata = 18'd0; start = 1'b0;
    cpu_inst_addr = 10'd0; cpu_data_addr = 10'd0; cpu_data_R = 1'b0;
    cpu_data_W = 1'b0; cpu_data_out = 16'd0; cpu_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    chk("rst_cpu_inst", {14'd0, cpu_inst}, 32'd0);
    chk("rst_cpu_data_in", {16'd0, cpu_data_in}, 32'd0);
    chk("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_finished", {31'd0, finished}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;

    // Preload and readback
    hwrite(1'b0, 10'd0, 18'h00005);
    hwrite(1'b0, 10'd1, 18'h0000F);
    hwrite(1'b0, 10'd2, 18'h00004);
    hwrite(1'b0, 10'd5, 18'h00000);
    hwrite(1'b0, 10'd88, 18'h00058);
    hwrite(1'b1, 10'd0, 18'h26000);
    hread(10'd1);
    chk("pre_rdata", {16'd0, host_rdata}, 32'h000F);
    chk("pre_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("pre_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("pre_cpu_inst", {14'd0, cpu_inst}, 32'h26000);
    tick();
    chk("pre_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);
    // Same-cycle host write and read return the old value
    host_re = 1'b1;
    hwrite(1'b0, 10'd1, 18'h00AAA);
    host_re = 1'b0;
    chk("wr_rd_old", {16'd0, host_rdata}, 32'h000F);
    hread(10'd1);
    chk("wr_rd_new", {16'd0, host_rdata}, 32'h0AAA);

    // Run and done after 7 RUN cycles
    do_start();
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("run_count0", {16'd0, cycle_count}, 32'd0);
    cpu_data_R = 1'b1; cpu_data_W = 1'b0; cpu_data_addr = 10'd2;
    tick();
    chk("run_read2", {16'd0, cpu_data_in}, 32'h0004);
    chk("run_count1", {16'd0, cycle_count}, 32'd1);
    cpu_data_W = 1'b1; cpu_data_addr = 10'd5; cpu_data_out = 16'h0014;
    tick();
    cpu_data_W = 1'b0;
    host_we = 1'b1; host_sel = 1'b0; host_addr = 10'd2; host_wdata = 18'h01234; host_re = 1'b1;
    tick();
    chk("run_read5", {16'd0, cpu_data_in}, 32'h0014);
    chk("run_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    host_we = 1'b0; host_re = 1'b0; cpu_data_R = 1'b0;
    repeat (3) tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("done_finished", {31'd0, finished}, 32'd1);
    chk("done_count", {16'd0, cycle_count}, 32'd7);
    chk("done_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("done_timeout", {31'd0, timeout}, 32'd0);
    hread(10'd5);
    chk("done_rd5", {16'd0, host_rdata}, 32'h0014);
    hread(10'd2);
    chk("ignored_host_we", {16'd0, host_rdata}, 32'h0004);

    // Timeout
    do_start();
    repeat (19) tick();
    chk("to_busy19", {31'd0, busy}, 32'd1);
    chk("to_count19", {16'd0, cycle_count}, 32'd19);
    tick();
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_finished", {31'd0, finished}, 32'd0);
    chk("to_count", {16'd0, cycle_count}, 32'd20);
    tick();
    chk("to_frozen", {16'd0, cycle_count}, 32'd20);

    // Done on the same edge as timeout
    do_start();
    repeat (19) tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("both_finished", {31'd0, finished}, 32'd1);
    chk("both_timeout", {31'd0, timeout}, 32'd0);
    chk("both_count", {16'd0, cycle_count}, 32'd20);

    // Out of range, host and core
    hwrite(1'b0, 10'd600, 18'h0BEEF);
    hread(10'd600);
    chk("oor_host_rd", {16'd0, host_rdata}, 32'h0000);
    do_start();
    cpu_data_R = 1'b1; cpu_data_W = 1'b1; cpu_data_addr = 10'd600; cpu_data_out = 16'hDEAD;
    tick();
    cpu_data_W = 1'b0;
    tick();
    cpu_data_R = 1'b0;
    chk("oor_cpu_rd", {16'd0, cpu_data_in}, 32'h0000);
    chk("oor_mem_err", {31'd0, mem_err}, {31'd0, ERR_EN});
    repeat (18) tick();
    chk("oor_halt_timeout", {31'd0, timeout}, 32'd1);
    chk("oor_err_sticky", {31'd0, mem_err}, {31'd0, ERR_EN});
    hread(10'd88);
    chk("oor_no_alias", {16'd0, host_rdata}, 32'h0058);
    do_start();
    chk("oor_err_clear", {31'd0, mem_err}, 32'd0);

    // Reset mid-run with memory retention
    cpu_data_R = 1'b1; cpu_data_W = 1'b1; cpu_data_addr = 10'd7; cpu_data_out = 16'h0777;
    tick();
    cpu_data_R = 1'b0; cpu_data_W = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("mid_count", {16'd0, cycle_count}, 32'd0);
    chk("mid_cpu_inst", {14'd0, cpu_inst}, 32'd0);
    chk("mid_host_rdata", {16'd0, host_rdata}, 32'd0);
    chk("mid_cpu_data_in", {16'd0, cpu_data_in}, 32'd0);
    hread(10'd7);
    chk("keep_rd7", {16'd0, host_rdata}, 32'h0777);
    hread(10'd5);
    chk("keep_rd5", {16'd0, host_rdata}, 32'h0014);
    tick();
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simd_mem_ctrl.md
# simd_mem_ctrl

Parametrised instruction/data memory and run controller for the SIMD processor core. It holds the instruction and data memories and gives the core its memory ports. It holds the core in reset while a host preloads programs and operands, then releases the core and counts cycles. The run ends on the core's done signal or on a timeout, after which the host reads results back. All logic runs on a single clock edge, and one controller covers any width and depth.

## Interface
Parameters:
- DATA_W, 16, data word width
- INST_W, 18, instruction width; must be ≥ DATA_W
- ADDR_W, 10, address width, shared by both memories
- IMEM_DEPTH, 1024, instruction words; must be ≤ 2^ADDR_W
- DMEM_DEPTH, 1024, data words; must be ≤ 2^ADDR_W
- TIMEOUT, 4095, maximum run cycles; must be < 2^16

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- host_we  in  1  host write strobe
- host_re  in  1  host read strobe (data memory only)
- host_sel  in  1  write target: 0 = data memory, 1 = instruction memory
- host_addr  in  ADDR_W  host address
- host_wdata  in  INST_W  host write data; data memory takes bits [DATA_W-1:0]
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid pulse
- start  in  1  begin a run
- busy  out  1  run in progress
- finished  out  1  last run ended on cpu_done
- timeout  out  1  last run ended on TIMEOUT
- cycle_count  out  16  cycles elapsed in current/last run
- mem_err  out  1  sticky out-of-range flag (see Configuration)
- cpu_rst_n  out  1  core reset, active-low
- cpu_inst_addr  in  ADDR_W  core instruction address
- cpu_inst  out  INST_W  instruction to core
- cpu_data_addr  in  ADDR_W  core data address
- cpu_data_R  in  1  core memory access enable
- cpu_data_W  in  1  with cpu_data_R: 1 = write, 0 = read
- cpu_data_out  in  DATA_W  core write data
- cpu_data_in  out  DATA_W  read data to core
- cpu_done  in  1  core program complete

## Operation
- FSM states: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE / HALT:
  - cpu_rst_n=0 and busy=0.
  - Host writes and reads are honoured.
  - start moves to RUN, clears finished, timeout and cycle_count, and sets cpu_rst_n=1 and busy=1 in that same transition.
- RUN:
  - Core ports are serviced.
  - cycle_count increments once per cycle.
  - Host writes, host reads and start are ignored; host_rvalid stays 0.
- RUN → HALT:
  - On cpu_done=1: set finished.
  - On cycle_count==TIMEOUT: set timeout.
  - If both happen in the same cycle, finished=1 and timeout=0.
  - On the transition, cpu_rst_n=0 and cycle_count freezes.
- Core data access:
  - cpu_data_R=1, cpu_data_W=1 writes cpu_data_out to DMEM[cpu_data_addr].
  - cpu_data_R=1, cpu_data_W=0 reads.
  - cpu_data_R=0: no access, and cpu_data_in holds its value.
- Out of range (address ≥ depth): writes are dropped and reads return 0. This applies to both the core and the host.
- Memory arrays are not cleared by reset. Contents persist across reset and across runs.
- Reset asserted mid-RUN: the next state is IDLE and all outputs take their reset values.

## Timing
- Reset values: host_rdata=0, host_rvalid=0, busy=0, finished=0, timeout=0, cycle_count=0, mem_err=0, cpu_rst_n=0, cpu_inst=0, cpu_data_in=0.
- cpu_inst is registered: it is valid 1 cycle after cpu_inst_addr, and is updated every cycle in all states.
- Core read: cpu_data_in is valid 1 cycle after the cpu_data_R=1 / cpu_data_W=0 request.
- Core write: takes effect at the edge where it is sampled. A read of the same address on the next cycle returns the new value.
- Host write: takes effect at the edge where host_we is sampled.
- Host read: host_rdata is valid and host_rvalid pulses 1 cycle after host_re.
- Host write and read to the same address in the same cycle: the read returns the old value.
- start to first serviced core access: 1 cycle, since cpu_rst_n rises at the start edge.
- cycle_count counts RUN cycles. It reads 1 after the first RUN edge and saturates at TIMEOUT.

## Configuration
- SIMD_MEM_ERR_EN defined:
  - mem_err is set on any core access (instruction fetch in RUN, or data access) to an address ≥ the corresponding depth.
  - It stays set until reset or the next start.
- SIMD_MEM_ERR_EN undefined: mem_err is tied 0, and no compare logic is built.
- Out-of-range data behaviour (writes dropped, reads return 0) is identical with or without the macro.

## Test plan
- Preload and readback:
  - Stimulus: in IDLE, host writes DMEM[0..2]=0x0005/0x000F/0x0004 and IMEM[0]=18'h26000; host_re at addr 1.
  - Response: host_rdata=0x000F with host_rvalid one cycle later; cpu_rst_n=0 throughout.
- Run and done:
  - Stimulus: start; core reads addr 2, then writes 0x0014 to addr 5; cpu_done after 7 RUN cycles.
  - Response: cpu_data_in=0x0004 one cycle after the read; finished=1, cycle_count=7, cpu_rst_n=0; host read of addr 5 returns 0x0014.
- Timeout:
  - Stimulus: TIMEOUT=20, start, cpu_done never asserted.
  - Response: HALT after 20 cycles, timeout=1, finished=0, cycle_count=20.
- Simultaneous end and ignored host access:
  - Stimulus: cpu_done in the same cycle cycle_count reaches TIMEOUT; separately, host_we during RUN.
  - Response: finished=1 and timeout=0; the memory location is unchanged.
- Reset mid-run and memory retention:
  - Stimulus: rst=0 for one cycle during RUN.
  - Response: IDLE with all reset values; a prior DMEM write is still readable by the host.
- Out of range:
  - Stimulus: DMEM_DEPTH=512, core writes addr 600, then reads addr 600.
  - Response: the read returns 0. With SIMD_MEM_ERR_EN, mem_err=1 until the next start; without it, mem_err=0.
